iq_collapse_param: RTL and testbench
====================================

# iq_collapse_param

Parametrised, age-ordered, collapsing issue queue that generalises the MDU issue queue to any depth, enqueue width, issue width and wakeup-bus width. It sits between dispatch and one functional-unit cluster. It holds renamed micro-ops until both source operands are ready, then issues the oldest ready ones. Freed slots compact every cycle.

## Interface
Parameters:
- `DEPTH`, 8: number of entries, ≥ 2.
- `ENQ_W`, 2: dispatch lanes.
- `DEQ_W`, 2: issue ports.
- `WAKE_W`, 4: wakeup broadcast lanes.
- `PREG_W`, 6: physical register tag width.
- `PAYLOAD_W`, 64: opaque micro-op payload width.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: pipeline flush; clears the queue.
- `enq_valid` in, ENQ_W: dispatch lane valid.
- `enq_data` in, ENQ_W×PAYLOAD_W: payload per lane.
- `enq_src_tag` in, ENQ_W×2×PREG_W: source tags.
- `enq_src_rdy` in, ENQ_W×2: source already ready at dispatch.
- `enq_ready` out, 1: queue accepts all ENQ_W lanes this cycle.
- `wake_valid` in, WAKE_W: wakeup lane valid.
- `wake_tag` in, WAKE_W×PREG_W: destination tag being woken.
- `issue_valid` out, DEQ_W: port k presents the k-th oldest ready entry.
- `issue_data` out, DEQ_W×PAYLOAD_W: payload of that entry.
- `issue_ready` in, DEQ_W: FU accepts port k.
- `count` out, $clog2(DEPTH+1): occupied entries.
- `empty` out, 1: count == 0.
- `full` out, 1: count == DEPTH.

## Operation
- Entries occupy slots 0..count-1. Slot 0 is the oldest. Slots ≥ count are invalid.
- **Enqueue**
  - Accepted lanes are those with `enq_valid` high while `enq_ready` is high.
  - Lanes with gaps are packed in lane order: lane 0 is older than lane 1.
  - Packed lanes are appended directly after the surviving entries.
- **enq_ready**
  - `enq_ready = (DEPTH - count) >= ENQ_W`, computed from registered `count` only.
  - Same-cycle issues are not credited, so no dequeue-to-enqueue combinational path exists.
  - `enq_valid` while `enq_ready` is low is ignored; dispatch must hold the lane.
- **Wakeup**
  - Each valid wake lane compares its tag against both source tags of every valid entry.
  - On a match, that source's ready bit sets at the next edge.
  - Ready bits never clear while the entry lives.
- **Select**
  - An entry is ready when both source ready bits are set.
  - Port k is driven by the k-th ready entry counting from slot 0.
  - `issue_valid[k]` is low when fewer than k+1 entries are ready.
- **Issue handshake**
  - An entry is removed iff its port has `issue_valid[k] && issue_ready[k]`.
  - Ports are independent: port 1 may fire while port 0 stalls.
- **Collapse**
  - next_count = count − fired + enqueued.
  - Survivors keep their relative order and shift down to fill holes in one cycle.
- **Flush**
  - `flush` wins over enqueue, wakeup and issue in the same cycle; next count = 0.
  - Handshakes in a flush cycle still occur on the ports, but the queue state is discarded.
- **Reset values**: count 0, all entries invalid, `issue_valid` 0, `enq_ready` 1, `empty` 1, `full` 0.

## Timing
- Issue outputs are combinational from entry registers only. `issue_valid` never depends on `issue_ready`.
- Enqueue at edge t: the entry is visible in cycle t+1 and can issue in t+1 if it is ready.
- Wake in cycle t: the matching entry can issue in t+1.
- Issue accepted in cycle t: the entry is gone and slots are compacted in cycle t+1.
- Simultaneous full drain and full enqueue: count reflects both at the next edge.
- The full and empty boundaries are exact.
- `rst_n` deassertion is synchronised by the top level; the block needs no special recovery.

## Configuration
- `IQ_WAKE_BYPASS_EN` defined:
  - Enqueue lanes also compare their source tags against the same-cycle `wake_tag`.
  - A match stores the source as ready.
- Undefined:
  - Sources are stored exactly as given by `enq_src_rdy`.
  - Dispatch must fold same-cycle wakeups into `enq_src_rdy` itself, otherwise the entry deadlocks.

## Structure
- Package `iq_pkg` holds:
  - `iq_entry_t` (valid, payload, `src_tag[2]`, `src_rdy[2]`).
  - The wake lane struct `iq_wake_t`.
  - Default parameter constants.
- Sub-module `iq_slot`, one per entry:
  - Holds the entry register and wakeup comparators.
  - Its next-state mux chooses among hold, shift from slot+j (j = 1..DEQ_W), enqueue lane m, and clear.
  - The parent computes the per-slot select signals from prefix counts of fired entries.

## Test plan
- Reset, then enqueue 2 ready ops (payload 0xA, 0xB) → next cycle `issue_valid`=2'b11, port0=0xA, port1=0xB, count=2.
- Fill to DEPTH=8, hold `enq_valid` → `enq_ready`=0 at count 7 and 8, `full`=1 at 8, no extra entry written.
- 3 entries with only slot 1 ready, `issue_ready`=1 → port0 carries slot 1. Next cycle count=2 and the old slot 2 is now slot 1.
- Entry waiting on tag 5, `wake_tag`=5 in cycle t → `issue_valid[0]`=1 in t+1.
- Same-cycle wake of tag 9 on an enqueue lane with src tag 9 → with `IQ_WAKE_BYPASS_EN` it issues in t+1; without it, it never issues.
- `flush` together with 2 enqueues and 1 issue at count 5 → next cycle count=0, `empty`=1, `issue_valid`=0.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types and default sizing for the collapsing issue queue.
package iq_pkg;

  localparam int unsigned IQ_DEPTH     = 8;
  localparam int unsigned IQ_ENQ_W     = 2;
  localparam int unsigned IQ_DEQ_W     = 2;
  localparam int unsigned IQ_WAKE_W    = 4;
  localparam int unsigned IQ_PREG_W    = 6;
  localparam int unsigned IQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic                           valid;
    logic [IQ_PAYLOAD_W-1:0]        payload;
    logic [1:0][IQ_PREG_W-1:0]      src_tag;
    logic [1:0]                     src_rdy;
  } iq_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [IQ_PREG_W-1:0] tag;
  } iq_wake_t;

  // Flat width of an entry with the iq_entry_t field layout at arbitrary sizes.
  function automatic int unsigned iq_entry_w(input int unsigned preg_w,
                                             input int unsigned payload_w);
    return 1 + payload_w + 2 * preg_w + 2;
  endfunction

endpackage

// File: rtl/iq_slot.sv
// One issue-queue entry: next-value mux (hold/shift/enqueue/clear) and wakeup comparators.
// Optional IQ_WAKE_BYPASS_EN: enqueued sources also match same-cycle wakeups.
module iq_slot
  import iq_pkg::*;
#(
  parameter int unsigned ENQ_W     = IQ_ENQ_W,
  parameter int unsigned DEQ_W     = IQ_DEQ_W,
  parameter int unsigned WAKE_W    = IQ_WAKE_W,
  parameter int unsigned PREG_W    = IQ_PREG_W,
  parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
  localparam int unsigned EW       = iq_entry_w(PREG_W, PAYLOAD_W)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [DEQ_W:0]                   shift_sel,
  input  logic [DEQ_W:1][EW-1:0]           shift_src,
  input  logic [ENQ_W-1:0]                 enq_sel,
  input  logic [ENQ_W-1:0][EW-1:0]         enq_src,
  input  logic [WAKE_W-1:0]                wake_valid,
  input  logic [WAKE_W-1:0][PREG_W-1:0]    wake_tag,
  output logic [EW-1:0]                    entry_o,
  output logic [PAYLOAD_W-1:0]             payload_o,
  output logic                             ready_c
);

  typedef struct packed {
    logic                       valid;
    logic [PAYLOAD_W-1:0]       payload;
    logic [1:0][PREG_W-1:0]     src_tag;
    logic [1:0]                 src_rdy;
  } entry_t;

  entry_t entry_q, entry_d, base;
  logic   use_wake;

  // Wakeups are applied to whatever value lands in this slot, so shifted entries never miss one.
  always_comb begin
    base     = '0;
    use_wake = 1'b0;
    if (!clear) begin
      if (shift_sel[0]) begin
        base     = entry_q;
        use_wake = 1'b1;
      end
      for (int j = 1; j <= int'(DEQ_W); j++) begin
        if (shift_sel[j]) begin
          base     = entry_t'(shift_src[j]);
          use_wake = 1'b1;
        end
      end
      for (int m = 0; m < int'(ENQ_W); m++) begin
        if (enq_sel[m]) begin
          base = entry_t'(enq_src[m]);
`ifdef IQ_WAKE_BYPASS_EN
          use_wake = 1'b1;
`endif
        end
      end
    end
    entry_d = base;
    if (use_wake && base.valid) begin
      for (int s = 0; s < 2; s++) begin
        for (int w = 0; w < int'(WAKE_W); w++) begin
          if (wake_valid[w] && (wake_tag[w] == base.src_tag[s])) entry_d.src_rdy[s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entry_o   = entry_q;
  assign payload_o = entry_q.payload;
  assign ready_c   = entry_q.valid & entry_q.src_rdy[0] & entry_q.src_rdy[1];

endmodule

// File: rtl/iq_collapse_param.sv
// Parametrised age-ordered collapsing issue queue: oldest-ready select, same-cycle compaction.
// Optional IQ_WAKE_BYPASS_EN: dispatch sources see same-cycle wakeups.
module iq_collapse_param
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH     = IQ_DEPTH,
  parameter int unsigned ENQ_W     = IQ_ENQ_W,
  parameter int unsigned DEQ_W     = IQ_DEQ_W,
  parameter int unsigned WAKE_W    = IQ_WAKE_W,
  parameter int unsigned PREG_W    = IQ_PREG_W,
  parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [ENQ_W-1:0]                    enq_valid,
  input  logic [ENQ_W-1:0][PAYLOAD_W-1:0]     enq_data,
  input  logic [ENQ_W-1:0][1:0][PREG_W-1:0]   enq_src_tag,
  input  logic [ENQ_W-1:0][1:0]               enq_src_rdy,
  output logic                                enq_ready,
  input  logic [WAKE_W-1:0]                   wake_valid,
  input  logic [WAKE_W-1:0][PREG_W-1:0]       wake_tag,
  output logic [DEQ_W-1:0]                    issue_valid,
  output logic [DEQ_W-1:0][PAYLOAD_W-1:0]     issue_data,
  input  logic [DEQ_W-1:0]                    issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                empty,
  output logic                                full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned EW    = iq_entry_w(PREG_W, PAYLOAD_W);

  logic [CNT_W-1:0]                  count_q, count_d;
  logic [DEPTH-1:0][EW-1:0]          slot_q;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]   slot_payload;
  logic [DEPTH-1:0]                  slot_ready;
  logic [DEPTH-1:0]                  fire;
  logic [DEPTH-1:0][CNT_W-1:0]       fired_pre;
  logic [CNT_W-1:0]                  rank, nfire, fired_tot, surv, epos, enq_acc;
  logic [ENQ_W-1:0][CNT_W-1:0]       lane_pos;
  logic [ENQ_W-1:0][EW-1:0]          enq_ent;
  logic [DEPTH-1:0][DEQ_W:0]         shift_sel;
  logic [DEPTH-1:0][ENQ_W-1:0]       enq_sel;
  logic                              unused_slot0;

  assign enq_ready    = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_W);
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign unused_slot0 = ^slot_q[0];

  // Port k takes the k-th ready slot from the oldest; fired_pre counts removals below each slot.
  always_comb begin
    issue_valid = '0;
    issue_data  = '0;
    fire        = '0;
    fired_pre   = '0;
    rank        = '0;
    nfire       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fired_pre[i] = nfire;
      if (slot_ready[i]) begin
        for (int k = 0; k < int'(DEQ_W); k++) begin
          if (rank == CNT_W'(k)) begin
            issue_valid[k] = 1'b1;
            issue_data[k]  = slot_payload[i];
            fire[i]        = issue_ready[k];
          end
        end
        rank = rank + CNT_W'(1);
      end
      if (fire[i]) nfire = nfire + CNT_W'(1);
    end
    fired_tot = nfire;
  end

  // Survivor at slot s moves down by fired_pre[s]; accepted lanes pack in after the survivors.
  always_comb begin
    surv      = count_q - fired_tot;
    epos      = surv;
    lane_pos  = '0;
    shift_sel = '0;
    enq_sel   = '0;
    enq_ent   = '0;
    for (int m = 0; m < int'(ENQ_W); m++) begin
      enq_ent[m]  = {1'b1, enq_data[m], enq_src_tag[m], enq_src_rdy[m]};
      lane_pos[m] = epos;
      if (enq_valid[m]) epos = epos + CNT_W'(1);
    end
    enq_acc = enq_ready ? (epos - surv) : '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j <= int'(DEQ_W); j++) begin
        if ((i + j) < int'(DEPTH)) begin
          if (((i + j) < int'(count_q)) && !fire[i+j] && (fired_pre[i+j] == CNT_W'(j)))
            shift_sel[i][j] = 1'b1;
        end
      end
      for (int m = 0; m < int'(ENQ_W); m++) begin
        if (enq_ready && enq_valid[m] && (lane_pos[m] == CNT_W'(i))) enq_sel[i][m] = 1'b1;
      end
    end
    count_d = flush ? '0 : (surv + enq_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
    logic [DEQ_W:1][EW-1:0] shift_src;
    for (genvar j = 1; j <= int'(DEQ_W); j++) begin : g_src
      if ((g + j) < int'(DEPTH)) begin : g_in
        assign shift_src[j] = slot_q[g+j];
      end else begin : g_pad
        assign shift_src[j] = '0;
      end
    end

    iq_slot #(
      .ENQ_W     (ENQ_W),
      .DEQ_W     (DEQ_W),
      .WAKE_W    (WAKE_W),
      .PREG_W    (PREG_W),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (flush),
      .shift_sel  (shift_sel[g]),
      .shift_src  (shift_src),
      .enq_sel    (enq_sel[g]),
      .enq_src    (enq_ent),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag),
      .entry_o    (slot_q[g]),
      .payload_o  (slot_payload[g]),
      .ready_c    (slot_ready[g])
    );
  end

endmodule

// File: tb/tb_iq_collapse_param.sv
// Randomised bench for iq_collapse_param against a queue-based reference model.
module tb_iq_collapse_param;

  localparam int DEPTH = 8, ENQ_W = 2, DEQ_W = 2, WAKE_W = 4, PREG_W = 6, PAYLOAD_W = 64;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              flush;
  logic [ENQ_W-1:0]                  enq_valid;
  logic [ENQ_W-1:0][PAYLOAD_W-1:0]   enq_data;
  logic [ENQ_W-1:0][1:0][PREG_W-1:0] enq_src_tag;
  logic [ENQ_W-1:0][1:0]             enq_src_rdy;
  logic                              enq_ready;
  logic [WAKE_W-1:0]                 wake_valid;
  logic [WAKE_W-1:0][PREG_W-1:0]     wake_tag;
  logic [DEQ_W-1:0]                  issue_valid;
  logic [DEQ_W-1:0][PAYLOAD_W-1:0]   issue_data;
  logic [DEQ_W-1:0]                  issue_ready;
  logic [3:0]                        count;
  logic                              empty, full;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [PREG_W-1:0]    tag0, tag1;
    bit                   rdy0, rdy1;
  } m_ent_t;

  m_ent_t m_q[$];

  iq_collapse_param #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W),
    .WAKE_W(WAKE_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_src_tag(enq_src_tag),
    .enq_src_rdy(enq_src_rdy), .enq_ready(enq_ready),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_ready(issue_ready),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit woken(input logic [PREG_W-1:0] t);
    for (int w = 0; w < WAKE_W; w++)
      if (wake_valid[w] && wake_tag[w] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    int nr = 0;
    logic [DEQ_W-1:0] ev = '0;
    logic [DEQ_W-1:0][PAYLOAD_W-1:0] ed = '0;
    foreach (m_q[i]) begin
      if (m_q[i].rdy0 && m_q[i].rdy1) begin
        if (nr < DEQ_W) begin
          ev[nr] = 1'b1;
          ed[nr] = m_q[i].payload;
        end
        nr++;
      end
    end
    check("count", 64'(count), 64'(m_q.size()));
    check("empty", 64'(empty), 64'(m_q.size() == 0));
    check("full", 64'(full), 64'(m_q.size() == DEPTH));
    check("enq_ready", 64'(enq_ready), 64'((DEPTH - m_q.size()) >= ENQ_W));
    check("issue_valid", 64'(issue_valid), 64'(ev));
    for (int k = 0; k < DEQ_W; k++)
      if (ev[k]) check($sformatf("issue_data%0d", k), issue_data[k], ed[k]);
  endtask

  task automatic model_update();
    int cnt0;
    bit enq_ok, byp;
    int rdy_idx[$];
    int kill[$];
    m_ent_t e;
`ifdef IQ_WAKE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    cnt0 = m_q.size();
    enq_ok = (DEPTH - cnt0) >= ENQ_W;
    if (flush) begin
      m_q.delete();
      return;
    end
    foreach (m_q[i]) if (m_q[i].rdy0 && m_q[i].rdy1) rdy_idx.push_back(i);
    for (int k = 0; k < DEQ_W; k++)
      if (k < rdy_idx.size() && issue_ready[k]) kill.push_front(rdy_idx[k]);
    foreach (kill[x]) m_q.delete(kill[x]);
    foreach (m_q[i]) begin
      if (woken(m_q[i].tag0)) m_q[i].rdy0 = 1'b1;
      if (woken(m_q[i].tag1)) m_q[i].rdy1 = 1'b1;
    end
    if (enq_ok) begin
      for (int m = 0; m < ENQ_W; m++) begin
        if (enq_valid[m]) begin
          e.payload = enq_data[m];
          e.tag0 = enq_src_tag[m][0];
          e.tag1 = enq_src_tag[m][1];
          e.rdy0 = enq_src_rdy[m][0] || (byp && woken(e.tag0));
          e.rdy1 = enq_src_rdy[m][1] || (byp && woken(e.tag1));
          m_q.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 1'b0; enq_valid = '0; enq_data = '0; enq_src_tag = '0; enq_src_rdy = '0;
    wake_valid = '0; wake_tag = '0; issue_ready = '0;
  endtask

  task automatic set_lane(input int m, input logic [63:0] p, input logic [PREG_W-1:0] t0,
                          input logic [PREG_W-1:0] t1, input logic [1:0] r);
    enq_valid[m] = 1'b1;
    enq_data[m] = p;
    enq_src_tag[m][0] = t0;
    enq_src_tag[m][1] = t1;
    enq_src_rdy[m] = r;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic rand_inputs();
    flush = ($urandom_range(0, 59) == 0);
    for (int m = 0; m < ENQ_W; m++) begin
      enq_valid[m] = ($urandom_range(0, 2) != 0);
      enq_data[m] = {$urandom, $urandom};
      enq_src_tag[m][0] = PREG_W'($urandom_range(0, 15));
      enq_src_tag[m][1] = PREG_W'($urandom_range(0, 15));
      enq_src_rdy[m] = 2'($urandom_range(0, 3));
    end
    for (int w = 0; w < WAKE_W; w++) begin
      wake_valid[w] = ($urandom_range(0, 2) == 0);
      wake_tag[w] = PREG_W'($urandom_range(0, 15));
    end
    issue_ready = DEQ_W'($urandom_range(0, (1 << DEQ_W) - 1));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_issue_valid", 64'(issue_valid), 64'(0));
    check("rst_enq_ready", 64'(enq_ready), 64'(1));
    tick();

    // two ready ops land in slots 0/1 and present on both ports
    set_lane(0, 64'hA, 6'd1, 6'd2, 2'b11);
    set_lane(1, 64'hB, 6'd3, 6'd4, 2'b11);
    tick();
    idle();
    check("tp1_valid", 64'(issue_valid), 64'(2'b11));
    check("tp1_port0", issue_data[0], 64'hA);
    check("tp1_port1", issue_data[1], 64'hB);
    tick();

    // fill through odd counts (stall at 7), then even counts up to full
    do_flush();
    set_lane(0, 64'h100, 6'd40, 6'd41, 2'b00);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 64'h200 + 64'(c), 6'd42, 6'd43, 2'b00);
      set_lane(1, 64'h300 + 64'(c), 6'd44, 6'd45, 2'b00);
      tick();
    end
    check("fill_cnt7", 64'(count), 64'(7));
    do_flush();
    for (int c = 0; c < 6; c++) begin
      set_lane(0, 64'h400 + 64'(c), 6'd46, 6'd47, 2'b00);
      set_lane(1, 64'h500 + 64'(c), 6'd48, 6'd49, 2'b00);
      tick();
    end
    check("fill_full", 64'(full), 64'(1));
    check("fill_cnt8", 64'(count), 64'(8));

    // only the middle of three entries is ready
    do_flush();
    set_lane(0, 64'hC0, 6'd50, 6'd51, 2'b00);
    set_lane(1, 64'hC1, 6'd52, 6'd53, 2'b11);
    tick();
    idle();
    set_lane(0, 64'hC2, 6'd54, 6'd55, 2'b01);
    tick();
    idle();
    issue_ready = '1;
    check("tp3_port0", issue_data[0], 64'hC1);
    tick();
    idle();
    check("tp3_cnt", 64'(count), 64'(2));
    tick();

    // wakeup of tag 5 makes the waiting entry issue next cycle
    do_flush();
    set_lane(0, 64'hD5, 6'd5, 6'd20, 2'b10);
    tick();
    idle();
    wake_valid[0] = 1'b1;
    wake_tag[0] = 6'd5;
    tick();
    idle();
    check("tp4_valid", 64'(issue_valid[0]), 64'(1));
    tick();

    // same-cycle wake of tag 9 at dispatch
    do_flush();
    set_lane(0, 64'hE9, 6'd9, 6'd21, 2'b10);
    wake_valid[2] = 1'b1;
    wake_tag[2] = 6'd9;
    tick();
    idle();
    issue_ready = '1;
    repeat (3) tick();

    // flush beats two enqueues and an issue at count 5
    do_flush();
    set_lane(0, 64'hF0, 6'd1, 6'd1, 2'b11);
    set_lane(1, 64'hF1, 6'd1, 6'd1, 2'b11);
    tick();
    tick();
    idle();
    set_lane(0, 64'hF4, 6'd1, 6'd1, 2'b11);
    tick();
    idle();
    flush = 1'b1;
    set_lane(0, 64'hF5, 6'd1, 6'd1, 2'b11);
    set_lane(1, 64'hF6, 6'd1, 6'd1, 2'b11);
    issue_ready = 2'b01;
    check("tp6_cnt5", 64'(count), 64'(5));
    tick();
    idle();
    check("tp6_cnt", 64'(count), 64'(0));
    check("tp6_empty", 64'(empty), 64'(1));
    check("tp6_valid", 64'(issue_valid), 64'(0));
    tick();

    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
